// File: rtl/uc_fetch_pkg.sv
// Shared types and default parameters for the nibble-CPU fetch/phase sequencer.
// The optional return stack is enabled by defining UC_CALL_STACK_EN.
package uc_fetch_pkg;

    localparam int ADDR_W_DEF    = 12;
    localparam int OPC_W_DEF     = 4;
    localparam int OPR_W_DEF     = 4;
    localparam int STK_DEPTH_DEF = 4;
    localparam logic [15:0] LONG_MASK_DEF = 16'hF000;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_FETCH2 = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

endpackage

// File: rtl/uc_fetch_if.sv
// Program-memory read bus between the fetch sequencer (master) and program memory (slave).
interface uc_fetch_if
    import uc_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = OPC_W_DEF + OPR_W_DEF
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport master (output mem_req, mem_addr, input mem_rdata, mem_valid);
    modport slave  (input mem_req, mem_addr, output mem_rdata, mem_valid);
endinterface

// File: rtl/uc_ret_stack.sv
// Small LIFO of return addresses; push when full and pop when empty are dropped,
// the caller decides how to flag them.
module uc_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 12
)(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  entries [DEPTH];
    logic [CW-1:0] cnt;
    logic [IW-1:0] top_idx;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign top_idx = IW'(cnt - 1'b1);
    assign top     = empty ? '0 : entries[top_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            entries[IW'(cnt)] <= din;
        end
    end

endmodule

// File: rtl/uc_fetch_sequencer.sv
// Instruction fetch/phase sequencer: owns PC and the instruction registers, fetches
// one- or two-byte instructions and gives the decoder a one-cycle execute phase.
// Optional call/return stack under UC_CALL_STACK_EN.
//
// state    | meaning
// S_FETCH  | request first byte at PC while run=1
// S_FETCH2 | request second byte of a long opcode (run ignored)
// S_EXEC   | single-cycle execute phase; PC loads/calls/returns applied here
module uc_fetch_sequencer
    import uc_fetch_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int OPC_W     = OPC_W_DEF,
    parameter int OPR_W     = OPR_W_DEF,
    parameter logic [(2**OPC_W)-1:0] LONG_MASK = LONG_MASK_DEF,
    parameter int STK_DEPTH = STK_DEPTH_DEF
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
    uc_fetch_if.master               mem,
    input  logic                     pc_load,
    input  logic [ADDR_W-1:0]        pc_load_addr,
    input  logic                     call_req,
    input  logic                     ret_req,
    output logic                     phase,
    output logic [OPC_W-1:0]         instr,
    output logic [OPR_W-1:0]         oprnd,
    output logic [OPC_W+OPR_W-1:0]   program_byte,
    output logic [ADDR_W-1:0]        PC,
    output logic                     stack_err
);
    localparam int DATA_W = OPC_W + OPR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic              ld_ir, ld_pb, req_c;
    logic [OPC_W-1:0]  fetched_opc;

    assign fetched_opc  = mem.mem_rdata[DATA_W-1 -: OPC_W];
    assign mem.mem_req  = req_c;
    assign mem.mem_addr = PC;

`ifdef UC_CALL_STACK_EN
    logic              push, pop, err_set, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;

    uc_ret_stack #(.DEPTH(STK_DEPTH), .W(ADDR_W)) u_ret_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (PC),
        .full  (stk_full),
        .empty (stk_empty),
        .top   (stk_top)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stack_err <= 1'b0;
        end else if (err_set) begin
            stack_err <= 1'b1;
        end
    end
`else
    logic unused_stack_inputs;
    assign unused_stack_inputs = call_req ^ ret_req ^ (STK_DEPTH > 0);
    assign stack_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = PC;
        ld_ir   = 1'b0;
        ld_pb   = 1'b0;
        req_c   = 1'b0;
        phase   = 1'b0;
`ifdef UC_CALL_STACK_EN
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                req_c = run;
                if (run && mem.mem_valid) begin
                    ld_ir   = 1'b1;
                    pc_d    = PC + 1'b1;
                    state_d = LONG_MASK[fetched_opc] ? S_FETCH2 : S_EXEC;
                end
            end
            S_FETCH2: begin
                req_c = 1'b1;
                if (mem.mem_valid) begin
                    ld_pb   = 1'b1;
                    pc_d    = PC + 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                phase   = 1'b1;
                state_d = S_FETCH;
`ifdef UC_CALL_STACK_EN
                // Underflow falls through to the already-incremented PC.
                if (ret_req) begin
                    if (stk_empty) begin
                        err_set = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end
                end else if (call_req) begin
                    pc_d = pc_load_addr;
                    if (stk_full) begin
                        err_set = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else if (pc_load) begin
                    pc_d = pc_load_addr;
                end
`else
                if (pc_load) begin
                    pc_d = pc_load_addr;
                end
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            PC           <= '0;
            instr        <= '0;
            oprnd        <= '0;
            program_byte <= '0;
        end else begin
            state_q <= state_d;
            PC      <= pc_d;
            if (ld_ir) begin
                {instr, oprnd} <= mem.mem_rdata;
            end
            if (ld_pb) begin
                program_byte <= mem.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_uc_fetch_sequencer.sv
// Directed bench for uc_fetch_sequencer with a variable-latency program memory model.
// Define UC_CALL_STACK_EN to exercise the return stack.
module tb_uc_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        pc_load = 1'b0;
    logic [11:0] pc_load_addr = '0;
    logic        call_req = 1'b0;
    logic        ret_req = 1'b0;
    logic        phase, stack_err;
    logic [3:0]  instr, oprnd;
    logic [7:0]  program_byte;
    logic [11:0] PC;

    logic [7:0]  mem_arr [0:4095];
    int          wait_cfg = 0;
    int          wcnt;
    logic        force_valid = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc;

    uc_fetch_if #(.ADDR_W(12), .DATA_W(8)) mem_bus ();

    uc_fetch_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .mem          (mem_bus.master),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .call_req     (call_req),
        .ret_req      (ret_req),
        .phase        (phase),
        .instr        (instr),
        .oprnd        (oprnd),
        .program_byte (program_byte),
        .PC           (PC),
        .stack_err    (stack_err)
    );

    always #5 clock = ~clock;

    // Memory answers after wait_cfg request cycles; reset drops any pending response.
    assign mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];
    assign mem_bus.mem_valid = (mem_bus.mem_req && (wcnt >= wait_cfg)) || force_valid;

    always @(posedge clock or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (mem_bus.mem_req && !mem_bus.mem_valid) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 4096; i++) mem_arr[i] = v;
    endtask

    task automatic do_reset();
        run = 1'b0; pc_load = 1'b0; call_req = 1'b0; ret_req = 1'b0; force_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_phase(input int maxc, output int c);
        logic seen;
        seen = 1'b0;
        c = -1;
        for (int i = 1; i <= maxc; i++) begin
            if (!seen) begin
                tick();
                if (phase === 1'b1) begin
                    c = i;
                    seen = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0;
        tick();
        n_total++; if (PC !== 12'h000) $display("FAIL reset_pc got %h want 000", PC); else n_pass++;
        n_total++; if ({instr, oprnd, program_byte} !== 16'h0000)
            $display("FAIL reset_regs got %h want 0000", {instr, oprnd, program_byte}); else n_pass++;
        n_total++; if ({phase, stack_err, mem_bus.mem_req} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {phase, stack_err, mem_bus.mem_req}); else n_pass++;
    endtask

    task automatic test_zero_wait();
        fill_mem(8'h00);
        mem_arr[0] = 8'h2A; mem_arr[1] = 8'h35;
        wait_cfg = 0;
        do_reset();
        run = 1'b1;
        #1;
        n_total++; if ({mem_bus.mem_req, mem_bus.mem_addr} !== {1'b1, 12'h000})
            $display("FAIL zw_req got %b/%h want 1/000", mem_bus.mem_req, mem_bus.mem_addr); else n_pass++;
        wait_phase(10, cyc);
        n_total++; if (cyc !== 1) $display("FAIL zw_lat1 got %0d want 1", cyc); else n_pass++;
        n_total++; if ({instr, oprnd, PC} !== {4'h2, 4'hA, 12'h001})
            $display("FAIL zw_instr1 got %h/%h/%h want 2/a/001", instr, oprnd, PC); else n_pass++;
        wait_phase(10, cyc);
        n_total++; if (cyc !== 2) $display("FAIL zw_lat2 got %0d want 2", cyc); else n_pass++;
        n_total++; if ({instr, oprnd, PC} !== {4'h3, 4'h5, 12'h002})
            $display("FAIL zw_instr2 got %h/%h/%h want 3/5/002", instr, oprnd, PC); else n_pass++;
    endtask

    task automatic test_long_wait();
        fill_mem(8'h00);
        mem_arr[0] = 8'hC7; mem_arr[1] = 8'h1F;
        wait_cfg = 2;
        do_reset();
        run = 1'b1;
        wait_phase(20, cyc);
        n_total++; if (cyc !== 6) $display("FAIL long_lat got %0d want 6", cyc); else n_pass++;
        n_total++; if ({instr, oprnd, program_byte, PC} !== {4'hC, 4'h7, 8'h1F, 12'h002})
            $display("FAIL long_regs got %h/%h/%h/%h want c/7/1f/002", instr, oprnd, program_byte, PC);
        else n_pass++;
    endtask

    task automatic test_wrap_and_load();
        fill_mem(8'h00);
        mem_arr[0] = 8'h2A; mem_arr[12'hFFF] = 8'h41; mem_arr[12'h123] = 8'h50;
        wait_cfg = 0;
        do_reset();
        run = 1'b1;
        wait_phase(10, cyc);
        pc_load = 1'b1; pc_load_addr = 12'hFFF;
        tick();
        pc_load = 1'b0;
        n_total++; if (mem_bus.mem_addr !== 12'hFFF)
            $display("FAIL load_fff got %h want fff", mem_bus.mem_addr); else n_pass++;
        wait_phase(10, cyc);
        n_total++; if ({instr, oprnd, PC} !== {4'h4, 4'h1, 12'h000})
            $display("FAIL wrap_pc got %h/%h/%h want 4/1/000", instr, oprnd, PC); else n_pass++;
        pc_load = 1'b1; pc_load_addr = 12'h123;
        tick();
        n_total++; if ({mem_bus.mem_req, mem_bus.mem_addr} !== {1'b1, 12'h123})
            $display("FAIL load_123 got %b/%h want 1/123", mem_bus.mem_req, mem_bus.mem_addr); else n_pass++;
        // pc_load held through a fetch with a wait state must not move PC
        wait_cfg = 1;
        pc_load_addr = 12'h055;
        wait_phase(10, cyc);
        pc_load = 1'b0;
        n_total++; if (cyc !== 2) $display("FAIL wait1_lat got %0d want 2", cyc); else n_pass++;
        n_total++; if ({instr, oprnd, PC} !== {4'h5, 4'h0, 12'h124})
            $display("FAIL load_ignored got %h/%h/%h want 5/0/124", instr, oprnd, PC); else n_pass++;
        tick();
    endtask

    task automatic test_run_drop();
        fill_mem(8'h00);
        mem_arr[0] = 8'hC7; mem_arr[1] = 8'h1F; mem_arr[2] = 8'h2A;
        wait_cfg = 1;
        do_reset();
        run = 1'b1;
        tick(); tick();
        run = 1'b0;
        #1;
        n_total++; if ({mem_bus.mem_req, mem_bus.mem_addr} !== {1'b1, 12'h001})
            $display("FAIL drop_f2_req got %b/%h want 1/001", mem_bus.mem_req, mem_bus.mem_addr); else n_pass++;
        wait_phase(10, cyc);
        n_total++; if (cyc !== 2) $display("FAIL drop_lat got %0d want 2", cyc); else n_pass++;
        n_total++; if ({program_byte, PC} !== {8'h1F, 12'h002})
            $display("FAIL drop_done got %h/%h want 1f/002", program_byte, PC); else n_pass++;
        tick(); tick();
        force_valid = 1'b1;
        tick(); tick();
        force_valid = 1'b0;
        n_total++; if ({mem_bus.mem_req, phase, instr, PC} !== {1'b0, 1'b0, 4'hC, 12'h002})
            $display("FAIL drop_idle got %b/%b/%h/%h want 0/0/c/002", mem_bus.mem_req, phase, instr, PC);
        else n_pass++;
        run = 1'b1;
        #1;
        n_total++; if ({mem_bus.mem_req, mem_bus.mem_addr} !== {1'b1, 12'h002})
            $display("FAIL resume_req got %b/%h want 1/002", mem_bus.mem_req, mem_bus.mem_addr); else n_pass++;
        wait_phase(10, cyc);
        n_total++; if ({instr, oprnd, PC} !== {4'h2, 4'hA, 12'h003})
            $display("FAIL resume_instr got %h/%h/%h want 2/a/003", instr, oprnd, PC); else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        fill_mem(8'h00);
        mem_arr[0] = 8'hC7; mem_arr[1] = 8'h1F;
        wait_cfg = 2;
        do_reset();
        run = 1'b1;
        tick(); tick(); tick(); tick();
        n_total++; if ({instr, PC} !== {4'hC, 12'h001})
            $display("FAIL pre_abort got %h/%h want c/001", instr, PC); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if ({PC, instr, phase, mem_bus.mem_addr} !== {12'h000, 4'h0, 1'b0, 12'h000})
            $display("FAIL abort got %h/%h/%b/%h want 000/0/0/000", PC, instr, phase, mem_bus.mem_addr);
        else n_pass++;
        tick();
        reset = 1'b0;
        wait_phase(20, cyc);
        n_total++; if (cyc !== 6) $display("FAIL restart_lat got %0d want 6", cyc); else n_pass++;
        n_total++; if ({instr, oprnd, program_byte, PC} !== {4'hC, 4'h7, 8'h1F, 12'h002})
            $display("FAIL restart_regs got %h/%h/%h/%h want c/7/1f/002", instr, oprnd, program_byte, PC);
        else n_pass++;
    endtask

`ifdef UC_CALL_STACK_EN
    task automatic test_call_stack();
        logic [11:0] exp_addr;
        fill_mem(8'h10);
        wait_cfg = 0;
        do_reset();
        run = 1'b1;
        wait_phase(10, cyc);
        for (int k = 1; k <= 5; k++) begin
            call_req = 1'b1; pc_load_addr = 12'(k * 256);
            tick();
            call_req = 1'b0;
            n_total++; if ({mem_bus.mem_addr, stack_err} !== {12'(k * 256), (k == 5)})
                $display("FAIL call%0d got %h/%b want %h/%b", k, mem_bus.mem_addr, stack_err,
                         12'(k * 256), (k == 5));
            else n_pass++;
            wait_phase(10, cyc);
        end
        for (int j = 1; j <= 5; j++) begin
            exp_addr = (j == 5) ? 12'h002 : 12'((4 - j) * 256 + 1);
            ret_req = 1'b1; call_req = 1'b1; pc_load_addr = 12'h7F0;
            tick();
            ret_req = 1'b0; call_req = 1'b0;
            n_total++; if ({mem_bus.mem_addr, stack_err} !== {exp_addr, 1'b1})
                $display("FAIL ret%0d got %h/%b want %h/1", j, mem_bus.mem_addr, stack_err, exp_addr);
            else n_pass++;
            wait_phase(10, cyc);
        end
    endtask
`else
    task automatic test_no_stack();
        fill_mem(8'h10);
        wait_cfg = 0;
        do_reset();
        run = 1'b1;
        wait_phase(10, cyc);
        call_req = 1'b1; ret_req = 1'b1; pc_load_addr = 12'h300;
        tick();
        call_req = 1'b0; ret_req = 1'b0;
        n_total++; if ({mem_bus.mem_addr, stack_err} !== {12'h001, 1'b0})
            $display("FAIL nostack got %h/%b want 001/0", mem_bus.mem_addr, stack_err); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_long_wait();
        test_wrap_and_load();
        test_run_drop();
        test_reset_mid_fetch();
`ifdef UC_CALL_STACK_EN
        test_call_stack();
`else
        test_no_stack();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
